// File: rtl/pong_game_ctrl_if.sv
// Pong controller bus: game-side inputs and score/state outputs.
// master drives ball/paddle/start, slave is the controller.
interface pong_game_ctrl_if #(
    parameter int c_GAME_WIDTH  = 40,
    parameter int c_GAME_HEIGHT = 30
);
    localparam int XW = $clog2(c_GAME_WIDTH);
    localparam int YW = $clog2(c_GAME_HEIGHT);

    logic          i_Game_Start;
    logic [XW-1:0] i_Ball_X;
    logic [YW-1:0] i_Ball_Y;
    logic [YW-1:0] i_P1_Paddle_Y;
    logic [YW-1:0] i_P2_Paddle_Y;
    logic          o_Game_Active;
    logic [3:0]    o_P1_Score;
    logic [3:0]    o_P2_Score;
    logic          o_Serve_Dir;
    logic [1:0]    o_Winner;

    modport master (
        output i_Game_Start,
        output i_Ball_X,
        output i_Ball_Y,
        output i_P1_Paddle_Y,
        output i_P2_Paddle_Y,
        input  o_Game_Active,
        input  o_P1_Score,
        input  o_P2_Score,
        input  o_Serve_Dir,
        input  o_Winner
    );

    modport slave (
        input  i_Game_Start,
        input  i_Ball_X,
        input  i_Ball_Y,
        input  i_P1_Paddle_Y,
        input  i_P2_Paddle_Y,
        output o_Game_Active,
        output o_P1_Score,
        output o_P2_Score,
        output o_Serve_Dir,
        output o_Winner
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong match controller: serve delay, miss detection, scoring, win.
// All outputs are registered straight from the FSM.
module pong_game_ctrl #(
    parameter int c_GAME_WIDTH    = 40,
    parameter int c_GAME_HEIGHT   = 30,
    parameter int c_PADDLE_HEIGHT = 6,
    parameter int c_SCORE_LIMIT   = 9,
    parameter int c_SERVE_DELAY   = 25000000
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    pong_game_ctrl_if.slave  bus
);
    localparam int XW = $clog2(c_GAME_WIDTH);
    localparam int YW = $clog2(c_GAME_HEIGHT);
    localparam int CW = $clog2(c_SERVE_DELAY + 1);

    typedef enum logic [2:0] {
        IDLE,
        SERVE_WAIT,
        RUNNING,
        P1_WINS,
        P2_WINS
    } state_t;

    state_t        state_q;
    logic          start_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    p1_score_q;
    logic [3:0]    p2_score_q;
    logic [3:0]    p1_score_d;
    logic [3:0]    p2_score_d;
    logic          dir_q;
    logic          active_q;
    logic [1:0]    winner_q;

    logic          start_edge;
    logic          p1_miss;
    logic          p2_miss;
    logic [YW:0]   ball_y;
    logic [YW:0]   p1_top;
    logic [YW:0]   p1_bot;
    logic [YW:0]   p2_top;
    logic [YW:0]   p2_bot;

    // One extra bit keeps top + height from wrapping near the bottom.
    always_comb begin
        start_edge = bus.i_Game_Start & ~start_q;
        ball_y     = {1'b0, bus.i_Ball_Y};
        p1_top     = {1'b0, bus.i_P1_Paddle_Y};
        p2_top     = {1'b0, bus.i_P2_Paddle_Y};
        p1_bot     = p1_top + (YW+1)'(c_PADDLE_HEIGHT);
        p2_bot     = p2_top + (YW+1)'(c_PADDLE_HEIGHT);
        p1_miss    = (bus.i_Ball_X == '0) &&
                     !((ball_y >= p1_top) && (ball_y < p1_bot));
        p2_miss    = (bus.i_Ball_X == XW'(c_GAME_WIDTH - 1)) &&
                     !((ball_y >= p2_top) && (ball_y < p2_bot));
        p1_score_d = p1_score_q + 4'd1;
        p2_score_d = p2_score_q + 4'd1;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q    <= IDLE;
            start_q    <= 1'b0;
            cnt_q      <= '0;
            p1_score_q <= 4'd0;
            p2_score_q <= 4'd0;
            dir_q      <= 1'b0;
            active_q   <= 1'b0;
            winner_q   <= 2'b00;
        end else begin
            start_q <= bus.i_Game_Start;
            unique case (state_q)
                IDLE, P1_WINS, P2_WINS: begin
                    if (start_edge) begin
                        state_q    <= SERVE_WAIT;
                        cnt_q      <= '0;
                        p1_score_q <= 4'd0;
                        p2_score_q <= 4'd0;
                        dir_q      <= 1'b0;
                        winner_q   <= 2'b00;
                    end
                end
                SERVE_WAIT: begin
                    if (cnt_q == CW'(c_SERVE_DELAY - 1)) begin
                        state_q  <= RUNNING;
                        cnt_q    <= '0;
                        active_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RUNNING: begin
                    if (p1_miss) begin
                        p2_score_q <= p2_score_d;
                        dir_q      <= 1'b0;
                        active_q   <= 1'b0;
                        if (p2_score_d == 4'(c_SCORE_LIMIT)) begin
                            state_q  <= P2_WINS;
                            winner_q <= 2'b10;
                        end else begin
                            state_q <= SERVE_WAIT;
                        end
                    end else if (p2_miss) begin
                        p1_score_q <= p1_score_d;
                        dir_q      <= 1'b1;
                        active_q   <= 1'b0;
                        if (p1_score_d == 4'(c_SCORE_LIMIT)) begin
                            state_q  <= P1_WINS;
                            winner_q <= 2'b01;
                        end else begin
                            state_q <= SERVE_WAIT;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_Game_Active = active_q;
    assign bus.o_P1_Score    = p1_score_q;
    assign bus.o_P2_Score    = p2_score_q;
    assign bus.o_Serve_Dir   = dir_q;
    assign bus.o_Winner      = winner_q;
endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 SHALL have parameter c_GAME_WIDTH, default 40: playfield width in game columns.
REQ-002 SHALL have parameter c_GAME_HEIGHT, default 30: playfield height in game rows.
REQ-003 SHALL have parameter c_PADDLE_HEIGHT, default 6: paddle length in rows.
REQ-004 SHALL have parameter c_SCORE_LIMIT, default 9: points needed to win (1..15).
REQ-005 SHALL have parameter c_SERVE_DELAY, default 25000000: cycles the ball is held before each serve (>=1).
REQ-006 SHALL have port i_Clk, input, 1: sole clock; all logic on rising edge.
REQ-007 SHALL have port i_Rst, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port i_Game_Start, input, 1: start button level, already debounced.
REQ-009 SHALL have port i_Ball_X, input, $clog2(c_GAME_WIDTH): ball column.
REQ-010 SHALL have port i_Ball_Y, input, $clog2(c_GAME_HEIGHT): ball row.
REQ-011 SHALL have port i_P1_Paddle_Y, input, $clog2(c_GAME_HEIGHT): top row of player 1 (left) paddle.
REQ-012 SHALL have port i_P2_Paddle_Y, input, $clog2(c_GAME_HEIGHT): top row of player 2 (right) paddle.
REQ-013 SHALL have port o_Game_Active, output, 1: high only in RUNNING; enables ball motion, low holds ball at centre.
REQ-014 SHALL have ports o_P1_Score and o_P2_Score, output, 4 each: current scores.
REQ-015 SHALL have port o_Serve_Dir, output, 1: 0 = serve toward P1 (left), 1 = toward P2 (right).
REQ-016 SHALL have port o_Winner, output, 2: 00 none, 01 P1, 10 P2; 11 never driven.

Function
REQ-017 SHALL implement FSM states IDLE, SERVE_WAIT, RUNNING, P1_WINS, P2_WINS; all outputs registered.
REQ-018 SHALL detect start as rising edge of i_Game_Start (registered previous value); a held level SHALL produce one event.
REQ-019 IDLE: on start edge -> SERVE_WAIT, both scores cleared to 0, o_Serve_Dir cleared to 0, serve counter cleared.
REQ-020 SERVE_WAIT: serve counter increments each cycle; when counter == c_SERVE_DELAY-1 -> RUNNING and counter clears; o_Game_Active rises on that same edge.
REQ-021 RUNNING: P1 miss SHALL be i_Ball_X == 0 AND NOT (i_P1_Paddle_Y <= i_Ball_Y < i_P1_Paddle_Y + c_PADDLE_HEIGHT).
REQ-022 RUNNING: P2 miss SHALL be i_Ball_X == c_GAME_WIDTH-1 AND ball row outside P2 paddle range, same inclusive/exclusive bounds.
REQ-023 Paddle-range comparison SHALL be done at $clog2(c_GAME_HEIGHT)+1 bits so top + height never wraps.
REQ-024 On P1 miss: o_P2_Score +1 on next edge; o_Serve_Dir <= 0 (serve toward the scoring-against player); if new score == c_SCORE_LIMIT -> P2_WINS, else -> SERVE_WAIT.
REQ-025 On P2 miss: o_P1_Score +1; o_Serve_Dir <= 1; if new score == c_SCORE_LIMIT -> P1_WINS, else -> SERVE_WAIT.
REQ-026 Exactly one point SHALL be awarded per miss, since leaving RUNNING blocks re-detection; ball at column 0 inside paddle range awards nothing.
REQ-027 P1_WINS / P2_WINS: o_Winner = 01 / 10, scores frozen, o_Game_Active 0; start edge -> SERVE_WAIT with scores, winner and o_Serve_Dir cleared.
REQ-028 Start edges in SERVE_WAIT or RUNNING SHALL be ignored.
REQ-029 Scores SHALL never exceed c_SCORE_LIMIT and SHALL not wrap.

Reset
REQ-030 i_Rst high at an edge SHALL force IDLE, both scores 0, o_Game_Active 0, o_Serve_Dir 0, o_Winner 00, serve counter 0, start-edge register 0, from any state incl. mid-serve-delay.
REQ-031 Reset SHALL take priority over every other event in the same cycle.

Verification (bench parameters c_SERVE_DELAY=4, c_SCORE_LIMIT=3)
REQ-032 Start: reset, hold i_Game_Start high 10 cycles -> one SERVE_WAIT entry, o_Game_Active high exactly 4 cycles after the start-edge state change, then stays high.
REQ-033 Miss vs hit: RUNNING, P1_Paddle_Y=10, Ball_X=0, Ball_Y=15 -> no score; Ball_Y=16 -> o_P2_Score 0->1, o_Serve_Dir 0, o_Game_Active low next cycle.
REQ-034 Bounds: P2_Paddle_Y=24, Ball_X=39, Ball_Y=29 -> no score; P2_Paddle_Y=23, Ball_Y=29 -> o_P1_Score +1, o_Serve_Dir 1.
REQ-035 Win: three P2 misses -> o_P1_Score 3, o_Winner 01, stays frozen with ball still at edge; start edge -> scores 0, winner 00, SERVE_WAIT.
REQ-036 Mid-operation reset: assert i_Rst at serve count 2 and again while RUNNING with scores 2-1 -> all outputs reset values next edge, state IDLE.
REQ-037 Ignored start: start edge during RUNNING -> scores and state unchanged.
